dmem_arbiter: RTL and testbench

Two-requester arbiter that shares the Datapath's single data-memory port (D_Addr/D_Wr/write data/read data) between the processor Control unit (CPU side) and an external host/loader port. It serialises accesses through a 3-state FSM and returns registered read data with a one-cycle ack. It supports round-robin fairness and a bounded host burst lock. It sits between Control/host and Datapath inside the processor top level.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU / host loader) arbiter for the single synchronous data-memory port.
// Build macro DMEM_ARB_FIXED_PRIO_EN: ties go to the CPU instead of round-robin.
module dmem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              host_req,
  input  logic              host_wr,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output logic [ADDR_W-1:0] D_Addr,
  output logic              D_Wr,
  output logic [DATA_W-1:0] D_WData,
  input  logic [DATA_W-1:0] D_RData,
  output logic              owner,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with wr/addr/wdata and holds them until its ack.
  // Requests are sampled only in IDLE; ack is a one-cycle pulse in RESP with rdata valid alongside.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam int BW = $clog2(MAX_BURST + 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_host_q, last_host_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic              wr_q, wr_d;
  logic              dwr_q, dwr_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] dwdata_q, dwdata_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              host_ack_q, host_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] host_rdata_q, host_rdata_d;

  logic burst_full;
  logic grant_host;

  assign burst_full = (burst_q >= BW'(MAX_BURST));

  always_comb begin
    grant_host = 1'b0;
    if (!(cpu_req && host_req)) begin
      grant_host = host_req;
    end else if (host_lock && !burst_full) begin
      grant_host = 1'b1;
    end else if (burst_full) begin
      grant_host = 1'b0;
    end else begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      grant_host = 1'b0;
`else
      grant_host = !last_host_q;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_host_d  = last_host_q;
    burst_d      = burst_q;
    wr_d         = wr_q;
    dwr_d        = 1'b0;
    daddr_d      = daddr_q;
    dwdata_d     = dwdata_q;
    cpu_ack_d    = 1'b0;
    host_ack_d   = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    host_rdata_d = host_rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (!host_lock) begin
          burst_d = '0;
        end
        if (cpu_req || host_req) begin
          state_d     = ST_ACCESS;
          owner_d     = grant_host;
          last_host_d = grant_host;
          wr_d        = grant_host ? host_wr    : cpu_wr;
          dwr_d       = grant_host ? host_wr    : cpu_wr;
          daddr_d     = grant_host ? host_addr  : cpu_addr;
          dwdata_d    = grant_host ? host_wdata : cpu_wdata;
          // Only locked host grants that make the CPU wait count toward the burst limit.
          if (!grant_host) begin
            burst_d = '0;
          end else if (host_lock && cpu_req && !burst_full) begin
            burst_d = burst_q + BW'(1);
          end
        end
      end
      ST_ACCESS: begin
        state_d    = ST_RESP;
        cpu_ack_d  = !owner_q;
        host_ack_d = owner_q;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (!wr_q) begin
          if (owner_q) host_rdata_d = D_RData;
          else         cpu_rdata_d  = D_RData;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= 1'b0;
      last_host_q  <= 1'b1;
      burst_q      <= '0;
      wr_q         <= 1'b0;
      dwr_q        <= 1'b0;
      daddr_q      <= '0;
      dwdata_q     <= '0;
      cpu_ack_q    <= 1'b0;
      host_ack_q   <= 1'b0;
      cpu_rdata_q  <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_host_q  <= last_host_d;
      burst_q      <= burst_d;
      wr_q         <= wr_d;
      dwr_q        <= dwr_d;
      daddr_q      <= daddr_d;
      dwdata_q     <= dwdata_d;
      cpu_ack_q    <= cpu_ack_d;
      host_ack_q   <= host_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // The memory returns read data during RESP, so the winner sees it alongside its ack.
  assign cpu_rdata  = (state_q == ST_RESP && !owner_q && !wr_q) ? D_RData : cpu_rdata_q;
  assign host_rdata = (state_q == ST_RESP &&  owner_q && !wr_q) ? D_RData : host_rdata_q;

  assign cpu_ack   = cpu_ack_q;
  assign host_ack  = host_ack_q;
  assign D_Addr    = daddr_q;
  assign D_Wr      = dwr_q;
  assign D_WData   = dwdata_q;
  assign owner     = owner_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios plus randomized traffic from both requesters.
module tb_dmem_arbiter;
  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic              Clk = 1'b0;
  logic              Reset = 1'b1;
  logic              cpu_req = 1'b0, cpu_wr = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              host_req = 1'b0, host_wr = 1'b0, host_lock = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_ack;
  logic [DATA_W-1:0] host_rdata;
  logic [ADDR_W-1:0] D_Addr;
  logic              D_Wr;
  logic [DATA_W-1:0] D_WData;
  logic [DATA_W-1:0] D_RData;
  logic              owner, busy;
  logic [1:0]        dbg_state;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int dwr_cnt = 0;
  int n_cpu_acks = 0;
  logic [ADDR_W-1:0] dwr_addr = '0;

  logic [DATA_W-1:0] mem [256];
  logic [DATA_W-1:0] ref_mem [256];
  bit                mem_filled = 1'b0;

  logic [DATA_W-1:0] exp_cpu_q[$];
  logic [DATA_W-1:0] exp_host_q[$];
  logic [DATA_W-1:0] cpu_last, host_last;
  bit                grant_q[$];
  int                grant_cyc_q[$];
  bit                exp_grant_q[$];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .Clk(Clk), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_lock(host_lock), .host_ack(host_ack), .host_rdata(host_rdata),
    .D_Addr(D_Addr), .D_Wr(D_Wr), .D_WData(D_WData), .D_RData(D_RData),
    .owner(owner), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return DATA_W'(i * 263) ^ 16'hA55A;
  endfunction

  // Synchronous-read data memory on the arbiter's port.
  always @(posedge Clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
      mem_filled <= 1'b1;
    end else if (D_Wr) begin
      mem[D_Addr] <= D_WData;
    end
    D_RData <= mem[D_Addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    cpu_req = 1'b0;
    host_req = 1'b0;
    host_lock = 1'b0;
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
    cpu_last = '0;
    host_last = '0;
    @(posedge Clk); #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic cpu_access(input bit wr, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wdata, input bit keep, output int ack_cyc);
    int t;
    if (wr) ref_mem[addr] = wdata;
    else    cpu_last = ref_mem[addr];
    exp_cpu_q.push_back(cpu_last);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    ack_cyc = -1;
    t = 0;
    while (t < 100) begin
      @(negedge Clk);
      if (cpu_ack) begin ack_cyc = cyc; break; end
      t++;
    end
    if (ack_cyc < 0) begin
      n_vec++; n_err++;
      $display("FAIL cpu_ack_timeout: no cpu_ack within 100 cycles, expected one");
    end
    @(posedge Clk); #1;
    if (!keep) cpu_req = 1'b0;
  endtask

  task automatic host_access(input bit wr, input logic [ADDR_W-1:0] addr,
                             input logic [DATA_W-1:0] wdata, input bit keep, output int ack_cyc);
    int t;
    if (wr) ref_mem[addr] = wdata;
    else    host_last = ref_mem[addr];
    exp_host_q.push_back(host_last);
    host_req = 1'b1; host_wr = wr; host_addr = addr; host_wdata = wdata;
    ack_cyc = -1;
    t = 0;
    while (t < 100) begin
      @(negedge Clk);
      if (host_ack) begin ack_cyc = cyc; break; end
      t++;
    end
    if (ack_cyc < 0) begin
      n_vec++; n_err++;
      $display("FAIL host_ack_timeout: no host_ack within 100 cycles, expected one");
    end
    @(posedge Clk); #1;
    if (!keep) host_req = 1'b0;
  endtask

  // ---------------- reference model: grant order for continuously requesting masters ----------------
  function automatic void model_grants(input int n_cpu, input int n_host, input bit lock);
    bit last_host;
    bit host_wins;
    int burst;
    last_host = 1'b1;
    burst = 0;
    exp_grant_q.delete();
    while (n_cpu > 0 || n_host > 0) begin
      if (n_cpu == 0)                         host_wins = 1'b1;
      else if (n_host == 0)                   host_wins = 1'b0;
      else if (lock && burst < MAX_BURST)     host_wins = 1'b1;
      else if (burst >= MAX_BURST)            host_wins = 1'b0;
      else                                    host_wins = FIXED_PRIO ? 1'b0 : !last_host;
      if (!host_wins || !lock) burst = 0;
      else if (n_cpu > 0 && burst < MAX_BURST) burst++;
      last_host = host_wins;
      exp_grant_q.push_back(host_wins);
      if (host_wins) n_host--; else n_cpu--;
    end
  endfunction

  task automatic compare_grants(input string tag);
    check({tag, "_grant_count"}, grant_q.size(), exp_grant_q.size());
    for (int i = 0; i < grant_q.size() && i < exp_grant_q.size(); i++) begin
      check($sformatf("%s_grant%0d", tag, i), grant_q[i], exp_grant_q[i]);
      if (i > 0) check($sformatf("%s_spacing%0d", tag, i), grant_cyc_q[i] - grant_cyc_q[i-1], 3);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    if (Reset) begin
      if (D_Wr) begin
        dwr_cnt++;
        dwr_addr = D_Addr;
      end
      if (cpu_ack || host_ack) check("ack_onehot", cpu_ack & host_ack, 0);
      if (cpu_ack) begin
        n_cpu_acks++;
        if (exp_cpu_q.size() == 0) check("cpu_ack_unexpected", cpu_ack, 0);
        else                       check("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
        grant_q.push_back(1'b0);
        grant_cyc_q.push_back(cyc);
      end
      if (host_ack) begin
        if (exp_host_q.size() == 0) check("host_ack_unexpected", host_ack, 0);
        else                        check("host_rdata", host_rdata, exp_host_q.pop_front());
        grant_q.push_back(1'b1);
        grant_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int ac, ac_c, ac_h, c0, snap;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    cpu_last = '0;
    host_last = '0;

    #1 Reset = 1'b0;
    #2;
    check("rst_D_Wr", D_Wr, 0);
    check("rst_D_Addr", D_Addr, 0);
    check("rst_D_WData", D_WData, 0);
    check("rst_cpu_ack", cpu_ack, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_owner", owner, 0);
    check("rst_busy", busy, 0);
    check("rst_state", dbg_state, 0);
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    @(posedge Clk); #1;

    // CPU write then read, with latency and single-cycle write strobe
    dwr_cnt = 0;
    c0 = cyc;
    cpu_access(1'b1, 8'h05, 16'h1234, 1'b0, ac);
    check("t1_wr_latency", ac - c0, 2);
    check("t1_dwr_cycles", dwr_cnt, 1);
    check("t1_dwr_addr", dwr_addr, 8'h05);
    check("t1_mem_written", mem[5], 16'h1234);
    c0 = cyc;
    cpu_access(1'b0, 8'h05, 16'h0000, 1'b0, ac);
    check("t1_rd_latency", ac - c0, 2);
    check("t1_cpu_rdata_hold", cpu_rdata, 16'h1234);
    check("t1_dwr_no_read_strobe", dwr_cnt, 1);

    // host write/read at the top address; CPU read data untouched
    host_access(1'b1, 8'hFF, 16'hBEEF, 1'b0, ac);
    host_access(1'b0, 8'hFF, 16'h0000, 1'b0, ac);
    check("t4_host_rdata_hold", host_rdata, 16'hBEEF);
    check("t4_cpu_rdata_unchanged", cpu_rdata, cpu_last);

    // both requesting continuously, no lock
    do_reset();
    grant_q.delete(); grant_cyc_q.delete();
    model_grants(4, 4, 1'b0);
    fork
      for (int i = 0; i < 4; i++) cpu_access(1'b1, 8'(8'h10 + i), 16'($urandom), i < 3, ac_c);
      for (int i = 0; i < 4; i++) host_access(i[0], 8'(8'h90 + i), 16'($urandom), i < 3, ac_h);
    join
    compare_grants("t2_rr");

    // host lock with burst limit
    do_reset();
    grant_q.delete(); grant_cyc_q.delete();
    host_lock = 1'b1;
    model_grants(2, 8, 1'b1);
    fork
      for (int i = 0; i < 2; i++) cpu_access(1'b1, 8'(8'h20 + i), 16'($urandom), i < 1, ac_c);
      for (int i = 0; i < 8; i++) host_access(1'b1, 8'(8'hA0 + i), 16'($urandom), i < 7, ac_h);
    join
    host_lock = 1'b0;
    compare_grants("t3_lock");

    // reset in the middle of a CPU write access
    do_reset();
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'hAAAA;
    @(posedge Clk); #1;
    check("t5_dwr_in_access", D_Wr, 1);
    check("t5_busy_in_access", busy, 1);
    snap = n_cpu_acks;
    Reset = 1'b0;
    #1;
    check("t5_dwr_reset", D_Wr, 0);
    check("t5_busy_reset", busy, 0);
    check("t5_owner_reset", owner, 0);
    cpu_req = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b1;
    cpu_last = '0; host_last = '0;
    repeat (3) @(posedge Clk);
    #1;
    check("t5_no_ack", n_cpu_acks, snap);
    grant_q.delete(); grant_cyc_q.delete();
    model_grants(1, 1, 1'b0);
    fork
      cpu_access(1'b1, 8'h34, 16'h5555, 1'b0, ac_c);
      host_access(1'b1, 8'hB4, 16'h6666, 1'b0, ac_h);
    join
    compare_grants("t5_tie");

    // randomized traffic: CPU in the low half, host in the high half of memory
    do_reset();
    fork
      begin
        int g;
        for (int i = 0; i < 30; i++) begin
          g = $urandom_range(0, 3);
          cpu_access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 16'($urandom),
                     (g == 0) && (i < 29), ac_c);
          repeat (g) begin @(posedge Clk); #1; end
        end
      end
      begin
        int g;
        for (int i = 0; i < 30; i++) begin
          g = $urandom_range(0, 3);
          host_lock = ($urandom_range(0, 2) == 0);
          host_access(1'($urandom_range(0, 1)), 8'($urandom_range(128, 255)), 16'($urandom),
                      (g == 0) && (i < 29), ac_h);
          repeat (g) begin @(posedge Clk); #1; end
        end
        host_lock = 1'b0;
      end
    join
    repeat (4) @(posedge Clk);
    #1;
    check("rand_cpu_q_drained", exp_cpu_q.size(), 0);
    check("rand_host_q_drained", exp_host_q.size(), 0);
    check("rand_idle", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
